pulse_burst_gen: RTL

- Transmit-side counterpart of the button-debounce/pulse-counter path: emits exactly N clean, fixed-width pulses on one wire.
- The existing debounced-tick counter consumes those pulses and must read exactly N.
- Used as a self-test stimulus source and as a general pulse-train driver.
- Start/busy/done handshake; N latched at start.

---
 rtl/pulse_burst_pkg.sv | 10 +
 rtl/phase_timer.sv | 16 +
 rtl/pulse_burst_gen.sv | 64 ++++++
 3 files changed

// File: rtl/pulse_burst_pkg.sv
// pulse_burst_pkg: shared state encoding and default sizing for the pulse burst generator.
package pulse_burst_pkg;
  typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} state_t;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_HIGH_CYC = 4;
  localparam int DEF_LOW_CYC = 4;
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/phase_timer.sv
// phase_timer: loadable down-counter; expired flags the last cycle of a phase.
module phase_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);
  logic [W-1:0] count;
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else count <= load ? load_val : count - W'(count != '0);
  assign expired = count == W'(1);
endmodule

// File: rtl/pulse_burst_gen.sv
// pulse_burst_gen: emits n fixed-width pulses with start/busy/done handshake.
// Optional abort input enabled by defining PULSE_BURST_ABORT_EN.
module pulse_burst_gen
  import pulse_burst_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int HIGH_CYC = DEF_HIGH_CYC,
  parameter int LOW_CYC = DEF_LOW_CYC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef PULSE_BURST_ABORT_EN
  input  logic             abort,
`endif
  input  logic [WIDTH-1:0] n,
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] remaining
);
  localparam int TW = $clog2(max2(HIGH_CYC, LOW_CYC) + 1);
  state_t state, state_n;
  logic expired, ab, load;
  logic [TW-1:0] load_val;
`ifdef PULSE_BURST_ABORT_EN
  assign ab = abort;
`else
  assign ab = 1'b0;
`endif
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = start ? (n != '0 ? HIGH : DONE) : IDLE;
      HIGH: state_n = ab ? DONE : !expired ? HIGH : (remaining == WIDTH'(1) ? DONE : LOW);
      LOW:  state_n = ab ? DONE : expired ? HIGH : LOW;
      default: state_n = IDLE;
    endcase
  end
  assign load = (state_n == HIGH || state_n == LOW) && state_n != state;
  assign load_val = state_n == HIGH ? TW'(HIGH_CYC) : TW'(LOW_CYC);
  phase_timer #(.W(TW)) u_timer (
    .clk(clk),
    .reset(reset),
    .load(load),
    .load_val(load_val),
    .expired(expired)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      pulse_out <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      remaining <= '0;
    end else begin
      state <= state_n;
      pulse_out <= state_n == HIGH;
      busy <= state_n != IDLE;
      done <= state_n == DONE;
      if (state == IDLE && start) remaining <= n;
      else if (state == HIGH && expired && !ab) remaining <= remaining - WIDTH'(1);
    end
endmodule
